// File: rtl/delta_decoder.sv
// Purpose: rebuild a sample stream from 2-bit delta-modulation spike codes; counts illegal codes.
// Latency: one cycle from spike_valid to recon/sat/recon_valid.
// Backpressure: none; every valid spike in RUN is consumed, so back-to-back spikes are accepted.
module delta_decoder #(
  parameter int WIDTH = 5,
  parameter int ERRW  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] init,
  input  logic [WIDTH-1:0] threshold,
  input  logic             spike_valid,
  input  logic [1:0]       spike,
  output logic [WIDTH-1:0] recon,
  output logic             recon_valid,
  output logic             sat,
  output logic             running,
  output logic [ERRW-1:0]  err_count
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Spike code points: bit0 = event, bit1 = down polarity.
  localparam logic [1:0] CODE_NONE    = 2'b00;
  localparam logic [1:0] CODE_UP      = 2'b01;
  localparam logic [1:0] CODE_ILLEGAL = 2'b10;
  localparam logic [1:0] CODE_DOWN    = 2'b11;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   recon_q, recon_d;
  logic [WIDTH:0]     step_q, step_d;
  logic               sat_q, sat_d;
  logic               recon_valid_q, recon_valid_d;
  logic [ERRW-1:0]    err_count_q, err_count_d;

  // Signed arithmetic two bits wider than the sample: one bit for the
  // step (up to 2^WIDTH) and one for the sign of an underflowing result.
  logic signed [WIDTH+1:0] recon_ext;
  logic signed [WIDTH+1:0] step_ext;
  logic signed [WIDTH+1:0] up_sum;
  logic signed [WIDTH+1:0] dn_diff;
  logic signed [WIDTH+1:0] max_ext;

  // Widen recon and step, form both candidate results.
  always_comb begin
    recon_ext = signed'({2'b00, recon_q});
    step_ext  = signed'({1'b0, step_q});
    max_ext   = signed'({2'b00, {WIDTH{1'b1}}});
    up_sum    = recon_ext + step_ext;
    dn_diff   = recon_ext - step_ext;
  end

  // Next-state and datapath: load has priority over any spike in the same cycle.
  always_comb begin
    state_d       = state_q;
    recon_d       = recon_q;
    step_d        = step_q;
    sat_d         = sat_q;
    recon_valid_d = 1'b0;
    err_count_d   = err_count_q;

    if (load) begin
      state_d = ST_RUN;
      recon_d = init;
      // Encoder only fires when |delta| > threshold, so one spike means threshold+1.
      step_d  = {1'b0, threshold} + {{WIDTH{1'b0}}, 1'b1};
      sat_d   = 1'b0;
    end else if (state_q == ST_RUN && spike_valid) begin
      recon_valid_d = 1'b1;
      unique case (spike)
        CODE_UP: begin
          if (up_sum > max_ext) begin
            recon_d = {WIDTH{1'b1}};
            sat_d   = 1'b1;
          end else begin
            recon_d = up_sum[WIDTH-1:0];
            sat_d   = 1'b0;
          end
        end
        CODE_DOWN: begin
          if (dn_diff < 0) begin
            recon_d = {WIDTH{1'b0}};
            sat_d   = 1'b1;
          end else begin
            recon_d = dn_diff[WIDTH-1:0];
            sat_d   = 1'b0;
          end
        end
        CODE_ILLEGAL: begin
          sat_d = 1'b0;
          if (err_count_q != {ERRW{1'b1}}) begin
            err_count_d = err_count_q + {{(ERRW-1){1'b0}}, 1'b1};
          end
        end
        CODE_NONE: begin
          sat_d = 1'b0;
        end
        default: begin
          sat_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      recon_q       <= {WIDTH{1'b0}};
      step_q        <= {{WIDTH{1'b0}}, 1'b1};
      sat_q         <= 1'b0;
      recon_valid_q <= 1'b0;
      err_count_q   <= {ERRW{1'b0}};
    end else begin
      state_q       <= state_d;
      recon_q       <= recon_d;
      step_q        <= step_d;
      sat_q         <= sat_d;
      recon_valid_q <= recon_valid_d;
      err_count_q   <= err_count_d;
    end
  end

  assign recon       = recon_q;
  assign recon_valid = recon_valid_q;
  assign sat         = sat_q;
  assign running     = (state_q == ST_RUN);
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_delta_decoder.sv
// Bench for delta_decoder: directed spike vectors, a cycle-level reference
// model of the decoder rules, and literal expectations at key points.
module tb_delta_decoder;

  localparam int WIDTH  = 5;
  localparam int ERRW   = 4;
  localparam int MAXV   = (1 << WIDTH) - 1;
  localparam int ERRMAX = (1 << ERRW) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] init = '0;
  logic [WIDTH-1:0] threshold = '0;
  logic             spike_valid = 1'b0;
  logic [1:0]       spike = 2'b00;
  logic [WIDTH-1:0] recon;
  logic             recon_valid;
  logic             sat;
  logic             running;
  logic [ERRW-1:0]  err_count;

  int checks = 0;
  int errors = 0;

  delta_decoder #(.WIDTH(WIDTH), .ERRW(ERRW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .init        (init),
    .threshold   (threshold),
    .spike_valid (spike_valid),
    .spike       (spike),
    .recon       (recon),
    .recon_valid (recon_valid),
    .sat         (sat),
    .running     (running),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: estimate as a plain integer, clamped to [0, MAXV].
  int m_est = 0;
  int m_step = 1;
  int m_err = 0;
  int m_sat = 0;
  int m_vld = 0;
  int m_run = 0;

  always @(posedge clk or negedge rst_n) begin
    int t;
    if (!rst_n) begin
      m_est = 0; m_step = 1; m_err = 0; m_sat = 0; m_vld = 0; m_run = 0;
    end else if (load) begin
      m_run = 1; m_est = int'(init); m_step = int'(threshold) + 1; m_sat = 0; m_vld = 0;
    end else if (m_run == 1 && spike_valid) begin
      m_vld = 1;
      if (spike == 2'b01) begin
        t = m_est + m_step;
        m_sat = (t > MAXV) ? 1 : 0;
        m_est = (t > MAXV) ? MAXV : t;
      end else if (spike == 2'b11) begin
        t = m_est - m_step;
        m_sat = (t < 0) ? 1 : 0;
        m_est = (t < 0) ? 0 : t;
      end else begin
        m_sat = 0;
        if (spike == 2'b10 && m_err < ERRMAX) m_err = m_err + 1;
      end
    end else begin
      m_vld = 0;
    end
  end

  // Every cycle, mid-period, all outputs must match the model.
  always @(negedge clk) begin
    chk("cyc_recon", int'(recon), m_est);
    chk("cyc_recon_valid", int'(recon_valid), m_vld);
    chk("cyc_sat", int'(sat), m_sat);
    chk("cyc_running", int'(running), m_run);
    chk("cyc_err_count", int'(err_count), m_err);
  end

  // Apply one cycle of inputs, then settle just after the following falling edge.
  task automatic tick(input logic ld, input int iv, input int th, input logic sv, input logic [1:0] sp);
    load = ld;
    init = WIDTH'(iv);
    threshold = WIDTH'(th);
    spike_valid = sv;
    spike = sp;
    @(posedge clk);
    @(negedge clk);
    #1;
    load = 1'b0;
    spike_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_recon", int'(recon), 0);
    chk("rst_valid", int'(recon_valid), 0);
    chk("rst_running", int'(running), 0);
    chk("rst_err", int'(err_count), 0);
    chk("rst_sat", int'(sat), 0);
    rst_n = 1'b1;

    // IDLE ignores spikes
    tick(0, 0, 0, 1, 2'b01);
    chk("idle_valid", int'(recon_valid), 0);
    chk("idle_recon", int'(recon), 0);
    chk("idle_running", int'(running), 0);
    tick(0, 0, 0, 1, 2'b10);
    chk("idle_err", int'(err_count), 0);

    // load then up spike
    tick(1, 10, 2, 0, 2'b00);
    chk("load_running", int'(running), 1);
    chk("load_recon", int'(recon), 10);
    tick(0, 0, 0, 1, 2'b01);
    chk("up_recon", int'(recon), 13);
    chk("up_valid", int'(recon_valid), 1);
    chk("up_sat", int'(sat), 0);
    tick(0, 0, 0, 0, 2'b00);
    chk("up_valid_drop", int'(recon_valid), 0);
    chk("hold_recon", int'(recon), 13);

    // illegal x3 then no-event
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, 1, 2'b10);
      chk("ill_valid", int'(recon_valid), 1);
    end
    tick(0, 0, 0, 1, 2'b00);
    chk("none_valid", int'(recon_valid), 1);
    chk("ill_recon", int'(recon), 13);
    chk("ill_err", int'(err_count), 3);
    chk("ill_sat", int'(sat), 0);

    // back-to-back down spikes
    tick(1, 10, 2, 0, 2'b00);
    tick(0, 0, 0, 1, 2'b11);
    chk("dn1_recon", int'(recon), 7);
    chk("dn1_valid", int'(recon_valid), 1);
    tick(0, 0, 0, 1, 2'b11);
    chk("dn2_recon", int'(recon), 4);
    chk("dn2_valid", int'(recon_valid), 1);

    // saturation and exact-limit cases
    tick(1, 30, 2, 0, 2'b00);
    tick(0, 0, 0, 1, 2'b01);
    chk("satup_recon", int'(recon), 31);
    chk("satup_sat", int'(sat), 1);
    tick(1, 1, 2, 0, 2'b00);
    chk("load_clears_sat", int'(sat), 0);
    tick(0, 0, 0, 1, 2'b11);
    chk("satdn_recon", int'(recon), 0);
    chk("satdn_sat", int'(sat), 1);
    tick(1, 28, 2, 0, 2'b00);
    tick(0, 0, 0, 1, 2'b01);
    chk("exact_recon", int'(recon), 31);
    chk("exact_sat", int'(sat), 0);
    tick(1, 0, 31, 0, 2'b00);
    tick(0, 0, 0, 1, 2'b01);
    chk("bigstep_up", int'(recon), 31);
    chk("bigstep_up_sat", int'(sat), 1);
    tick(1, 31, 31, 0, 2'b00);
    tick(0, 0, 0, 1, 2'b11);
    chk("bigstep_dn", int'(recon), 0);
    chk("bigstep_dn_sat", int'(sat), 1);
    tick(1, 31, 30, 0, 2'b00);
    tick(0, 0, 0, 1, 2'b11);
    chk("exact0_recon", int'(recon), 0);
    chk("exact0_sat", int'(sat), 0);

    // error counter saturation (3 already counted)
    for (int i = 0; i < 20; i++) tick(0, 0, 0, 1, 2'b10);
    chk("err_sat", int'(err_count), 15);

    // load beats a same-cycle spike
    tick(1, 5, 0, 1, 2'b01);
    chk("prio_recon", int'(recon), 5);
    chk("prio_valid", int'(recon_valid), 0);
    chk("prio_err", int'(err_count), 15);
    tick(0, 0, 0, 1, 2'b01);
    chk("prio_next", int'(recon), 6);

    // asynchronous reset mid-stream
    rst_n = 1'b0; #2; rst_n = 1'b1;
    tick(1, 20, 0, 0, 2'b00);
    tick(0, 0, 0, 1, 2'b10);
    tick(0, 0, 0, 1, 2'b10);
    chk("pre_rst_recon", int'(recon), 20);
    chk("pre_rst_err", int'(err_count), 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_recon", int'(recon), 0);
    chk("arst_err", int'(err_count), 0);
    chk("arst_running", int'(running), 0);
    @(posedge clk); @(negedge clk); #1;
    rst_n = 1'b1;
    tick(0, 0, 0, 1, 2'b01);
    chk("post_rst_valid", int'(recon_valid), 0);
    chk("post_rst_recon", int'(recon), 0);
    tick(1, 3, 1, 0, 2'b00);
    tick(0, 25, 7, 1, 2'b01);
    chk("no_reseed", int'(recon), 5);

    @(posedge clk); @(negedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/delta_decoder.md
# delta_decoder

Reconstructs a sample stream from the 2-bit on/off spike codes produced by the delta-modulation encoder. The block holds a running estimate and steps it up or down by a programmed step on each valid spike, saturating at the unsigned range limits. It sits at the receive end of the spike link and presents the reconstructed sample with a one-cycle valid strobe. It also counts illegal codes for debug.

## Interface
- WIDTH, 5: sample width; matches the encoder's data/threshold width.
- ERRW, 4: width of the illegal-code counter.

- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- load  input  1  one-cycle command: seed estimate and step, enter RUN.
- init  input  WIDTH  initial estimate, sampled when load=1.
- threshold  input  WIDTH  encoder threshold, sampled when load=1.
- spike_valid  input  1  spike code on `spike` is present this cycle.
- spike  input  2  code: bit0 = event, bit1 = off (down) polarity.
- recon  output  WIDTH  reconstructed sample (registered).
- recon_valid  output  1  one-cycle pulse: recon updated from a spike.
- sat  output  1  registered: last update clipped at 0 or 2^WIDTH-1.
- running  output  1  high in RUN state.
- err_count  output  ERRW  saturating count of illegal codes received in RUN.

## Operation
- States: IDLE, RUN. Reset enters IDLE.
- IDLE: spike_valid ignored (no recon_valid, no error count). load=1 -> RUN.
- RUN: load=1 re-seeds and stays in RUN.
- On load: recon <= init; step <= threshold + 1, computed in WIDTH+1 bits, so threshold=2^WIDTH-1 gives step 2^WIDTH; sat <= 0; err_count unchanged; recon_valid <= 0.
- Step rationale: the encoder fires only when |delta| > threshold, so the minimum represented change is threshold+1.
- Spike decode in RUN, when spike_valid=1:
  - 2'b01 is an up event: recon <= min(recon + step, 2^WIDTH-1).
  - 2'b11 is a down event: recon <= max(recon - step, 0).
  - 2'b00 is no event: recon unchanged, sat <= 0.
  - 2'b10 is illegal: recon unchanged, sat <= 0, and err_count increments, saturating at 2^ERRW-1.
  - In all four cases recon_valid pulses one cycle.
- Arithmetic is performed in WIDTH+2 bits signed. sat <= 1 only when clipping actually occurred. A result landing exactly on a limit without clipping gives sat=0.
- load and spike_valid in the same cycle: load wins and the spike is dropped (no recon_valid, no error count).
- spike_valid=0 in RUN: all outputs hold, and recon_valid=0.

## Timing
- Reset values (asynchronous, immediate): recon=0, recon_valid=0, sat=0, running=0, err_count=0, step=1, state=IDLE.
- Latency is one cycle: spike sampled at edge N; recon, sat and recon_valid are valid after edge N and readable during cycle N+1.
- running rises the cycle after the load edge.
- Back-to-back spike_valid every cycle is supported, giving one update per cycle with recon_valid held high continuously.
- threshold and init changes outside a load cycle have no effect.
- Reset asserted mid-stream clears all state asynchronously. Spikes arriving after deassertion are ignored until the next load.

## Test plan
- Reset then load init=10, threshold=2, then spike 01: next cycle recon=13, recon_valid=1, sat=0; the following cycle recon_valid=0.
- After load init=10, threshold=2, spikes 11, 11 back-to-back: recon 7 then 4, recon_valid high for two consecutive cycles.
- Saturation: load init=30, threshold=2, spike 01 -> recon=31, sat=1. Load init=1, spike 11 -> recon=0, sat=1. Load init=28, spike 01 -> recon=31, sat=0.
- Illegal and idle codes: in RUN with recon=13, send spike 10 three times then 00: recon stays 13, err_count=3, recon_valid pulses four times, sat=0. With ERRW=4, 20 illegal codes -> err_count=15.
- Priority and IDLE: spike 01 before any load -> no recon_valid, recon=0. In RUN, load (init=5, threshold=0) with spike_valid=1, spike=01 in the same cycle -> recon=5, no recon_valid. Next spike 01 -> recon=6.
- Reset mid-stream: in RUN at recon=20, err_count=2, assert rst_n low between edges -> recon=0, err_count=0, running=0 immediately. After release, spikes are ignored until load.
